// File: rtl/seg_display_pkg.sv
// Shared constants for the multiplexed seven-segment display: active-low
// digit patterns (bit0 = segment a) and the refresh divider computation.
package seg_display_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int unsigned NUM_DIGITS = 8;

  // Clock cycles each digit stays lit.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned digit_hz);
    return clk_hz / digit_hz;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (nibble)
      4'h0: seg_n = SEG_0;
      4'h1: seg_n = SEG_1;
      4'h2: seg_n = SEG_2;
      4'h3: seg_n = SEG_3;
      4'h4: seg_n = SEG_4;
      4'h5: seg_n = SEG_5;
      4'h6: seg_n = SEG_6;
      4'h7: seg_n = SEG_7;
      4'h8: seg_n = SEG_8;
      4'h9: seg_n = SEG_9;
      4'hA: seg_n = SEG_A;
      4'hB: seg_n = SEG_B;
      4'hC: seg_n = SEG_C;
      4'hD: seg_n = SEG_D;
      4'hE: seg_n = SEG_E;
      4'hF: seg_n = SEG_F;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Eight-digit hex scanner for a common-anode display. Values arrive over
// valid/ready and are promoted only at frame boundaries so a frame never tears.
module seg_scan_display
  import seg_display_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned DIGIT_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_in,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic        hold,
  input  logic        blank_lz,
  output logic [6:0]  seg_n,
  output logic [7:0]  an_n,
  output logic        frame_done
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, DIGIT_HZ);
  localparam int unsigned PRE_W = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("seg_scan_display: CLK_HZ/DIGIT_HZ must be at least 2");
    end
  endgenerate

  logic [PRE_W-1:0] prescaler_reg, prescaler_next;
  logic [2:0]       digit_reg, digit_next;
  logic             tick_d_reg;
  logic [31:0]      shown_reg;
  logic [31:0]      pending_reg;
  logic             pending_full_reg;
  logic [6:0]       seg_n_reg, seg_n_next;
  logic [7:0]       an_n_reg, an_n_next;
  logic             frame_done_reg;

  logic tick;
  logic frame_end;
  logic capture;
  logic promote;

  assign tick      = (prescaler_reg == PRE_LAST);
  assign frame_end = tick && (digit_reg == 3'd7);
  assign capture   = value_valid && !pending_full_reg;
  assign promote   = frame_end && pending_full_reg && !hold;

  assign prescaler_next = tick ? '0 : prescaler_reg + 1'b1;
  assign digit_next     = tick ? digit_reg + 3'd1 : digit_reg;

  // blank_mask[k] is set when digit k and every digit to its left are zero.
  logic [NUM_DIGITS-1:0] blank_mask;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_lsd
        assign blank_mask[gi] = 1'b0;
      end else begin : g_upper
        assign blank_mask[gi] = (shown_reg[31:4*gi] == '0);
      end
    end
  endgenerate

  logic [3:0] cur_nibble;
  logic [6:0] cur_seg_n;
  logic       cur_blank;

  assign cur_nibble = shown_reg[{digit_reg, 2'b00} +: 4];
  assign cur_blank  = blank_lz && blank_mask[digit_reg];

  hex_to_seg u_hex_to_seg (
    .nibble (cur_nibble),
    .seg_n  (cur_seg_n)
  );

  always_comb begin
    seg_n_next = seg_n_reg;
    an_n_next  = an_n_reg;
    if (tick_d_reg) begin
      an_n_next  = ~(8'b1 << digit_reg);
      seg_n_next = cur_blank ? SEG_BLANK : cur_seg_n;
    end
  end

  // Scan timing and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler_reg  <= '0;
      digit_reg      <= 3'd0;
      tick_d_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
      seg_n_reg      <= SEG_BLANK;
      an_n_reg       <= 8'hFF;
    end else begin
      prescaler_reg  <= prescaler_next;
      digit_reg      <= digit_next;
      tick_d_reg     <= tick;
      frame_done_reg <= frame_end;
      seg_n_reg      <= seg_n_next;
      an_n_reg       <= an_n_next;
    end
  end

  // Capture and promotion are exclusive: one needs the slot empty, the other full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shown_reg        <= '0;
      pending_reg      <= '0;
      pending_full_reg <= 1'b0;
    end else begin
      if (promote) begin
        shown_reg        <= pending_reg;
        pending_full_reg <= 1'b0;
      end else if (capture) begin
        pending_reg      <= value_in;
        pending_full_reg <= 1'b1;
      end
    end
  end

  assign value_ready = !pending_full_reg;
  assign seg_n       = seg_n_reg;
  assign an_n        = an_n_reg;
  assign frame_done  = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display with DIV=8; the expected display is
// derived from the edge count since reset and a pending/shown value model.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] value_in = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic        hold = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg_n;
  logic [7:0]  an_n;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  // Reference state: edges since reset release, pending slot and shown value.
  int          m = 0;
  logic [31:0] m_shown = '0;
  logic [31:0] m_pending = '0;
  bit          m_full = 1'b0;
  logic [7:0]  exp_an = 8'hFF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_fd = 1'b0;
  bit          last_cap = 1'b0;
  bit          last_prom = 1'b0;
  int          promotions = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg_scan_display #(.CLK_HZ(80), .DIGIT_HZ(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .hold        (hold),
    .blank_lz    (blank_lz),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_done  (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h edge=%0d", tag, obs, exp, m);
    end
  endtask

  task automatic check_all();
    check("an_n", 32'(an_n), 32'(exp_an));
    check("seg_n", 32'(seg_n), 32'(exp_seg));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    check("value_ready", 32'(value_ready), 32'(!m_full));
  endtask

  // One clock edge: advance the model from the inputs seen at the edge, then check.
  task automatic step();
    int d;
    bit cap;
    bit prom;
    @(posedge clk);
    m++;
    prom = (m % 64 == 0) && m_full && !hold;
    cap  = value_valid && !m_full;
    if (m > 1 && (m % 8) == 1) begin
      d = ((m - 1) / 8) % 8;
      exp_an = ~(8'b1 << d);
      if (blank_lz && d != 0 && (m_shown >> (4 * d)) == 0)
        exp_seg = 7'h7F;
      else
        exp_seg = seg_tab[m_shown[4*d +: 4]];
    end
    exp_fd = (m % 64 == 0);
    if (prom) begin
      m_shown = m_pending;
      m_full = 1'b0;
      promotions++;
    end
    if (cap) begin
      m_pending = value_in;
      m_full = 1'b1;
    end
    last_cap = cap;
    last_prom = prom;
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic offer(input logic [31:0] v);
    value_in = v;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
  endtask

  task automatic model_reset();
    m = 0;
    m_shown = '0;
    m_full = 1'b0;
    exp_an = 8'hFF;
    exp_seg = 7'h7F;
    exp_fd = 1'b0;
  endtask

  initial begin
    int n;
    int prom_before;
    bit got;

    // Power-up reset: dark outputs, ready high.
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    $display("step: reset released");

    run(70);
    blank_lz = 1'b1;
    run(64);
    $display("step: idle frames done, blank_lz=1 checked");

    blank_lz = 1'b0;
    offer(32'h1234ABCD);
    $display("step: offered 1234ABCD");
    run(140);

    blank_lz = 1'b1;
    offer(32'h00000F00);
    $display("step: offered 00000F00 with blanking");
    run(130);

    hold = 1'b1;
    offer(32'hFFFFFFFF);
    $display("step: offered FFFFFFFF under hold");
    run(140);
    check("hold_backpressure", 32'(value_ready), 32'd0);
    check("hold_shown_kept", m_shown, 32'h00000F00);
    hold = 1'b0;
    run(70);
    check("hold_release_promoted", m_shown, 32'hFFFFFFFF);

    // Fill the slot, then keep valid high on a second value across frame_end.
    while ((m % 64) != 40) step();
    offer(32'hCAFE0123);
    prom_before = promotions;
    value_in = 32'h55555555;
    value_valid = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      step();
      n++;
      if (last_prom) check("no_capture_on_promotion_edge", 32'(value_ready), 32'd1);
      if (last_cap) got = 1'b1;
    end
    value_valid = 1'b0;
    check("second_value_captured", 32'(got), 32'd1);
    check("one_promotion_before_capture", 32'(promotions - prom_before), 32'd1);
    check("first_value_shown", m_shown, 32'hCAFE0123);
    run(70);
    check("second_value_shown", m_shown, 32'h55555555);
    $display("step: collision of frame_end and valid done");

    // Reset mid-frame while digit 3 is dwelling and the slot is full.
    while ((m % 64) != 5) step();
    offer(32'h87654321);
    n = 0;
    while (((m / 8) % 8) != 3 && n < 100) begin
      step();
      n++;
    end
    check("mid_frame_digit_reached", 32'((m / 8) % 8), 32'd3);
    check("mid_frame_pending_full", 32'(value_ready), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    $display("step: asynchronous reset mid-frame");
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    run(80);
    $display("step: post-reset frame done");

    // Randomised traffic, honouring the stable-while-stalled rule.
    for (int i = 0; i < 900; i++) begin
      if (!(value_valid && m_full)) begin
        value_in = $urandom;
        if ($urandom_range(0, 3) == 0) value_in = value_in >> (4 * $urandom_range(0, 7));
        value_valid = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 99) == 0) hold = ~hold;
      blank_lz = $urandom_range(0, 1);
      step();
    end
    hold = 1'b0;
    value_valid = 1'b0;
    run(70);
    $display("step: random traffic done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
